// File: rtl/usb_pkg.sv
// Shared USB transmit-path constants and the bit-stuffer state encoding.
package usb_pkg;
    localparam int   BS_MAX_ONES = 6;
    localparam logic NRZI_J      = 1'b1;

    typedef enum logic [1:0] {BS_IDLE, BS_ACTIVE, BS_STUFF, BS_EOP} bs_state_t;
endpackage

// File: rtl/nrzi_enc.sv
// NRZI line encoder: a 0 toggles the line, a 1 holds it; output registered one cycle after en.
module nrzi_enc #(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    input  logic clr_idle,
    output logic out_valid,
    output logic out_bit
);
    logic nrzi_q;
    logic valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nrzi_q  <= IDLE_LEVEL;
            valid_q <= 1'b0;
        end else begin
            valid_q <= en;
            if (en)
                nrzi_q <= d ? nrzi_q : ~nrzi_q;
            else if (clr_idle)
                nrzi_q <= IDLE_LEVEL;
        end
    end

    assign out_valid = valid_q;
    assign out_bit   = nrzi_q;
endmodule

// File: rtl/bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after MAX_ONES consecutive 1s, NRZI-encodes, flags EOP.
module bit_stuffer
    import usb_pkg::*;
#(
    parameter int   MAX_ONES   = BS_MAX_ONES,
    parameter logic IDLE_LEVEL = NRZI_J
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic endr,
    input  logic s_in,
    output logic pause,
    output logic out_valid,
    output logic out_bit,
    output logic pkt_end,
    output logic busy
);
    localparam int CW = $clog2(MAX_ONES + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_ONES);

    bs_state_t     state, state_d;
    logic [CW-1:0] ones_cnt, ones_d, ones_inc;
    logic          end_pend, pend_d;
    logic          emit, emit_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BS_IDLE;
            ones_cnt <= '0;
            end_pend <= 1'b0;
        end else begin
            state    <= state_d;
            ones_cnt <= ones_d;
            end_pend <= pend_d;
        end
    end

    assign ones_inc = ones_cnt + 1'b1;

    always_comb begin
        state_d = state;
        ones_d  = ones_cnt;
        pend_d  = end_pend;
        emit    = 1'b0;
        emit_d  = 1'b0;
        unique case (state)
            BS_IDLE: begin
                if (start) begin
                    state_d = BS_ACTIVE;
                    ones_d  = '0;
                    pend_d  = 1'b0;
                end
            end
            BS_ACTIVE: begin
                if (endr) begin
                    state_d = BS_EOP;
                end else begin
                    emit   = 1'b1;
                    emit_d = s_in;
                    if (s_in) begin
                        ones_d = ones_inc;
                        if (ones_inc == MAX_C)
                            state_d = BS_STUFF;
                    end else begin
                        ones_d = '0;
                    end
                end
            end
            BS_STUFF: begin
                // The stuffed 0 always goes out, even when the packet ends here.
                emit   = 1'b1;
                emit_d = 1'b0;
                ones_d = '0;
                if (endr)
                    pend_d = 1'b1;
                state_d = (end_pend || endr) ? BS_EOP : BS_ACTIVE;
            end
            BS_EOP: begin
                state_d = BS_IDLE;
            end
            default: state_d = BS_IDLE;
        endcase
    end

    assign pause   = (state == BS_STUFF);
    assign pkt_end = (state == BS_EOP);
    assign busy    = (state != BS_IDLE);

    nrzi_enc #(.IDLE_LEVEL(IDLE_LEVEL)) u_nrzi (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (emit),
        .d        (emit_d),
        .clr_idle (state == BS_EOP),
        .out_valid(out_valid),
        .out_bit  (out_bit)
    );
endmodule
